// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter that serializes 64-bit accesses from two requesters onto
// a single byte-wide memory port, little-endian, one byte beat per cycle.
module dmem_port_arbiter #(
    parameter  int ADDR_W    = 6,
    parameter  int NUM_BYTES = 8,
    localparam int DATA_W    = 8 * NUM_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    localparam int BEAT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_rr_ptr;
    logic                r_owner;
    logic                r_we;
    logic [DATA_W-9:0]   r_wdata_sh;
    logic [DATA_W-9:0]   r_rbuf;
    logic                r_ack0;
    logic                r_ack1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic                r_mem_we;
    logic                r_mem_re;

    logic                w_any_req;
    logic                w_sel;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [DATA_W-1:0]   w_rdata_full;

    // Contention goes to rr_ptr; a lone requester wins outright.
    assign w_any_req   = req0 | req1;
    assign w_sel       = (req0 & req1) ? r_rr_ptr : req1;
    assign w_sel_we    = w_sel ? we1    : we0;
    assign w_sel_addr  = w_sel ? addr1  : addr0;
    assign w_sel_wdata = w_sel ? wdata1 : wdata0;

    // Earlier beats shift down so byte 0 ends up in the low lane after the last beat.
    assign w_rdata_full = {mem_rdata, r_rbuf};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_rr_ptr    <= 1'b0;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_wdata_sh  <= '0;
            r_rbuf      <= '0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_sel;
                        r_rr_ptr    <= ~w_sel;
                        r_we        <= w_sel_we;
                        r_beat      <= '0;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_we ? w_sel_wdata[7:0] : 8'h00;
                        r_wdata_sh  <= w_sel_wdata[DATA_W-1:8];
                        r_mem_we    <= w_sel_we;
                        r_mem_re    <= ~w_sel_we;
                        r_state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    r_rbuf <= w_rdata_full[DATA_W-1:8];
                    if (r_beat == LAST_BEAT) begin
                        r_mem_we    <= 1'b0;
                        r_mem_re    <= 1'b0;
                        r_mem_wdata <= 8'h00;
                        r_state     <= S_DONE;
                        if (r_owner) begin
                            r_ack1   <= 1'b1;
                            r_rdata1 <= r_we ? '0 : w_rdata_full;
                        end else begin
                            r_ack0   <= 1'b1;
                            r_rdata0 <= r_we ? '0 : w_rdata_full;
                        end
                    end else begin
                        r_beat      <= r_beat + BEAT_W'(1);
                        r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                        r_mem_wdata <= r_we ? r_wdata_sh[7:0] : 8'h00;
                        r_wdata_sh  <= r_wdata_sh >> 8;
                    end
                end
                S_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: byte memory model, reference memory image
// and an ack scoreboard holding the expected owner and read data in grant order.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [5:0]  addr0, addr1;
    logic [63:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [63:0] rdata0, rdata1;
    logic        busy;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_re;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem     [64];
    logic [7:0]  ref_mem [64];
    logic        poke_en;
    logic [5:0]  poke_addr;
    logic [7:0]  poke_data;
    logic        ack_prev;

    typedef struct {
        logic        port;
        logic [63:0] data;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_port_arbiter #(.ADDR_W(6), .NUM_BYTES(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (poke_en) mem[poke_addr] <= poke_data;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_read(input logic [5:0] a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[(int'(a) + k) % 64];
        return r;
    endfunction

    task automatic expect_read(input logic p, input logic [5:0] a);
        sb_q.push_back('{port: p, data: ref_read(a)});
    endtask

    task automatic expect_write(input logic p, input logic [5:0] a, input logic [63:0] d);
        for (int k = 0; k < 8; k++) ref_mem[(int'(a) + k) % 64] = d[8*k +: 8];
        sb_q.push_back('{port: p, data: 64'h0});
    endtask

    task automatic drive(input logic p, input logic we, input logic [5:0] a, input logic [63:0] d);
        if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    endtask

    // Waits (bounded) for the port's ack; with exp_lat >= 0 also checks latency and every beat.
    task automatic wait_ack(input logic p, input int exp_lat, input logic [5:0] base,
                            input logic we, input logic [63:0] d, input logic drop);
        int   cnt = 0;
        int   k   = 0;
        logic got = 1'b0;
        while (!got && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (exp_lat >= 0 && (mem_we || mem_re)) begin
                chk("beat_addr", 64'(mem_addr), 64'((int'(base) + k) % 64));
                chk("beat_we", 64'(mem_we), 64'(we));
                if (we) chk("beat_wdata", 64'(mem_wdata), 64'(d[8*k +: 8]));
                k++;
            end
            if (p ? ack1 : ack0) got = 1'b1;
        end
        chk(p ? "ack1_seen" : "ack0_seen", 64'(got), 64'd1);
        if (exp_lat >= 0) begin
            chk("latency", 64'(cnt), 64'(exp_lat));
            chk("beat_count", 64'(k), 64'd8);
        end
        if (drop) begin
            if (p) req1 = 1'b0;
            else   req0 = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (ack0 || ack1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", 64'({ack1, ack0}), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ack_port", 64'({ack1, ack0}), e.port ? 64'd2 : 64'd1);
                chk("ack_rdata", e.port ? rdata1 : rdata0, e.data);
                $display("ack port%0d rdata=%h expected=%h", e.port, e.port ? rdata1 : rdata0, e.data);
            end
            chk("ack_one_cycle", 64'(ack_prev), 64'd0);
        end
        ack_prev <= ack0 | ack1;
    end

    initial begin
        logic [63:0] d5;
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            poke_en   = 1'b1;
            poke_addr = 6'(i);
            poke_data = (i == 0) ? 8'h08 : (i >= 16 && i < 24) ? 8'(8'hA0 + i) : 8'h00;
            ref_mem[i] = poke_data;
        end
        @(negedge clk);
        poke_en = 1'b0;

        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack0", 64'(ack0), 64'd0);
        chk("rst_ack1", 64'(ack1), 64'd0);
        chk("rst_rdata0", rdata0, 64'd0);
        chk("rst_rdata1", rdata1, 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_re", 64'(mem_re), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single read of byte 0
        drive(1'b0, 1'b0, 6'd0, 64'h0);
        expect_read(1'b0, 6'd0);
        wait_ack(1'b0, 9, 6'd0, 1'b0, 64'h0, 1'b1);
        @(negedge clk);

        // Port 1 write then port 0 read back
        drive(1'b1, 1'b1, 6'd8, 64'h1122334455667788);
        expect_write(1'b1, 6'd8, 64'h1122334455667788);
        wait_ack(1'b1, 9, 6'd8, 1'b1, 64'h1122334455667788, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 6'd8, 64'h0);
        expect_read(1'b0, 6'd8);
        wait_ack(1'b0, 9, 6'd8, 1'b0, 64'h0, 1'b1);
        @(negedge clk);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Contention from reset, then port 0 re-requests at its ack while port 1 waits
        drive(1'b0, 1'b0, 6'd0, 64'h0);
        drive(1'b1, 1'b0, 6'd8, 64'h0);
        expect_read(1'b0, 6'd0);
        expect_read(1'b1, 6'd8);
        expect_read(1'b0, 6'd62);
        wait_ack(1'b0, 9, 6'd0, 1'b0, 64'h0, 1'b0);
        addr0 = 6'd62;
        wait_ack(1'b1, 10, 6'd8, 1'b0, 64'h0, 1'b1);
        wait_ack(1'b0, 10, 6'd62, 1'b0, 64'h0, 1'b1);
        @(negedge clk);

        // Write wrapping past the top of memory, then read it back
        drive(1'b0, 1'b1, 6'd62, 64'h0706050403020100);
        expect_write(1'b0, 6'd62, 64'h0706050403020100);
        wait_ack(1'b0, 9, 6'd62, 1'b1, 64'h0706050403020100, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 6'd62, 64'h0);
        expect_read(1'b0, 6'd62);
        wait_ack(1'b0, 9, 6'd62, 1'b0, 64'h0, 1'b1);
        @(negedge clk);

        // Reset during beat 3 of a write: only bytes 16..18 land
        d5 = 64'hC7C6C5C4C3C2C1C0;
        drive(1'b0, 1'b1, 6'd16, d5);
        repeat (4) @(negedge clk);
        chk("abort_addr", 64'(mem_addr), 64'd19);
        chk("abort_we_before", 64'(mem_we), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_we_after", 64'(mem_we), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        req0 = 1'b0;
        for (int k = 0; k < 3; k++) ref_mem[16 + k] = d5[8*k +: 8];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b0, 6'd16, 64'h0);
        expect_read(1'b0, 6'd16);
        wait_ack(1'b0, 9, 6'd16, 1'b0, 64'h0, 1'b1);
        @(negedge clk);

        // Port 1 holds req; port 0 arrives mid-transfer and is served next
        drive(1'b1, 1'b0, 6'd8, 64'h0);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b0, 6'd0, 64'h0);
        expect_read(1'b1, 6'd8);
        expect_read(1'b0, 6'd0);
        expect_read(1'b1, 6'd8);
        wait_ack(1'b1, -1, 6'd8, 1'b0, 64'h0, 1'b0);
        wait_ack(1'b0, 10, 6'd0, 1'b0, 64'h0, 1'b1);
        wait_ack(1'b1, 10, 6'd8, 1'b0, 64'h0, 1'b1);
        repeat (3) @(negedge clk);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
